// File: rtl/fifo_async_prog.sv
// Dual-clock FIFO with Gray-coded pointer synchronisers, programmable full/empty
// thresholds, sticky overflow/underflow flags and a choice of FWFT or registered read.
module fifo_async_prog #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 1
) (
  input  logic          clk_wr,
  input  logic          clk_rd,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic [AW:0]   prog_full_thresh,
  output logic          full,
  output logic          alfull,
  output logic          progfull,
  output logic [AW:0]   wr_count,
  output logic          overflow,
  input  logic          rd_en,
  input  logic [AW:0]   prog_empty_thresh,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          empty,
  output logic          alempty,
  output logic          progempty,
  output logic [AW:0]   rd_count,
  output logic          underflow
);

  if (DW < 1) begin : g_bad_dw
    $error("fifo_async_prog: DW must be >= 1");
  end
  if (AW < 2) begin : g_bad_aw
    $error("fifo_async_prog: AW must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_async_prog: SYNC_STAGES must be >= 2");
  end

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] DEPTH_M1 = DEPTH_C - ONE_C;

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  // Write domain
  logic [AW:0] wr_p, wr_g, wr_p_next, wr_count_next, rd_p_sync_w;
  logic [AW:0] rd_g_sync [SYNC_STAGES];
  logic [AW:0] rd_g;
  logic        wr_acc;

  assign wr_acc        = wr_en & ~full;
  assign wr_p_next     = wr_p + {{AW{1'b0}}, wr_acc};
  assign rd_p_sync_w   = gray2bin(rd_g_sync[SYNC_STAGES-1]);
  assign wr_count_next = wr_p_next - rd_p_sync_w;

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      wr_p     <= '0;
      wr_g     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rd_g_sync[i] <= '0;
      wr_count <= '0;
      full     <= 1'b0;
      alfull   <= 1'b0;
      progfull <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_p         <= wr_p_next;
      wr_g         <= bin2gray(wr_p_next);
      rd_g_sync[0] <= rd_g;
      for (int i = 1; i < SYNC_STAGES; i++) rd_g_sync[i] <= rd_g_sync[i-1];
      wr_count     <= wr_count_next;
      full         <= (wr_count_next == DEPTH_C);
      alfull       <= (wr_count_next >= DEPTH_M1);
      progfull     <= (wr_count_next >= prog_full_thresh);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; reset discards words by clearing pointers.
  always_ff @(posedge clk_wr) begin
    if (wr_acc) mem[wr_p[AW-1:0]] <= din;
  end

  // Read domain
  logic [AW:0] rd_p, rd_p_next, rd_count_next, wr_p_sync_r;
  logic [AW:0] wr_g_sync [SYNC_STAGES];
  logic        rd_acc;

  assign rd_acc        = rd_en & ~empty;
  assign rd_p_next     = rd_p + {{AW{1'b0}}, rd_acc};
  assign wr_p_sync_r   = gray2bin(wr_g_sync[SYNC_STAGES-1]);
  assign rd_count_next = wr_p_sync_r - rd_p_next;

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      rd_p      <= '0;
      rd_g      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wr_g_sync[i] <= '0;
      rd_count  <= '0;
      empty     <= 1'b1;
      alempty   <= 1'b1;
      progempty <= 1'b1;
      underflow <= 1'b0;
    end else begin
      rd_p         <= rd_p_next;
      rd_g         <= bin2gray(rd_p_next);
      wr_g_sync[0] <= wr_g;
      for (int i = 1; i < SYNC_STAGES; i++) wr_g_sync[i] <= wr_g_sync[i-1];
      rd_count     <= rd_count_next;
      empty        <= (rd_count_next == '0);
      alempty      <= (rd_count_next <= ONE_C);
      progempty    <= (rd_count_next <= prog_empty_thresh);
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown combinationally; zeros while nothing is available.
    assign valid = ~empty;
    assign dout  = empty ? '0 : mem[rd_p[AW-1:0]];
  end else begin : g_std
    logic [DW-1:0] dout_q;
    logic          valid_q;

    always_ff @(posedge clk_rd or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_p[AW-1:0]];
      end
    end

    assign valid = valid_q;
    assign dout  = dout_q;
  end

endmodule
